// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a big-endian, byte-addressed, 3-byte-word data memory.
// Adds byte loads (zero/sign-extended) and byte stores (read-modify-write) plus address range faults.
module load_store_unit #(
    parameter int MEM_BYTES  = 128,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic                  ReqByte,
    input  logic                  ReqSigned,
    input  logic [DATA_WIDTH-1:0] ReqAddress,
    input  logic [DATA_WIDTH-1:0] ReqWriteData,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [DATA_WIDTH-1:0] RespData,
    output logic                  RespFault,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] MemReadData
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

    localparam logic [DATA_WIDTH-1:0] MAX_ADDR = DATA_WIDTH'(MEM_BYTES - 3);

    state_t                state_q, state_d;
    logic                  byte_q, byte_d;
    logic                  sgn_q, sgn_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;   // load result, or merged word during a byte store
    logic [7:0]            rd_byte;

    // Big-endian: the addressed byte is the most significant byte of the word.
    assign rd_byte = MemReadData[DATA_WIDTH-1 -: 8];

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            byte_q  <= 1'b0;
            sgn_q   <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            sgn_q   <= sgn_d;
            fault_q <= fault_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        sgn_d        = sgn_q;
        fault_d      = fault_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        ReqReady     = 1'b0;
        RespValid    = 1'b0;
        RespData     = '0;
        RespFault    = 1'b0;
        MemAddress   = '0;
        MemWriteData = '0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // State is already IDLE while reset is held; keep ready low until release.
                ReqReady = ResetN;
                if (ReqValid) begin
                    byte_d  = ReqByte;
                    sgn_d   = ReqSigned;
                    addr_d  = ReqAddress;
                    wdata_d = ReqWriteData;
                    data_d  = '0;
                    fault_d = ReqAddress > MAX_ADDR;
                    if (ReqAddress > MAX_ADDR) state_d = RESP;
                    else if (!ReqWrite)        state_d = LOAD;
                    else if (ReqByte)          state_d = RMW_RD;
                    else                       state_d = STORE;
                end
            end
            LOAD: begin
                MemRead    = 1'b1;
                MemAddress = addr_q;
                if (!byte_q)    data_d = MemReadData;
                else if (sgn_q) data_d = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
                else            data_d = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
                state_d = RESP;
            end
            RMW_RD: begin
                MemRead    = 1'b1;
                MemAddress = addr_q;
                data_d     = {wdata_q[7:0], MemReadData[DATA_WIDTH-9:0]};
                state_d    = STORE;
            end
            STORE: begin
                MemWrite     = 1'b1;
                MemAddress   = addr_q;
                MemWriteData = byte_q ? data_q : wdata_q;
                data_d       = '0;
                state_d      = RESP;
            end
            RESP: begin
                RespValid = 1'b1;
                RespData  = data_q;
                RespFault = fault_q;
                if (RespReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: memory model, reference memory, per-cycle output compare.
module tb_load_store_unit;

    logic        Clock = 1'b0, ResetN = 1'b0;
    logic        ReqValid = 1'b0, ReqWrite = 1'b0, ReqByte = 1'b0, ReqSigned = 1'b0, RespReady = 1'b0;
    logic [23:0] ReqAddress = '0, ReqWriteData = '0;
    logic        ReqReady, RespValid, RespFault, MemWrite, MemRead;
    logic [23:0] RespData, MemAddress, MemWriteData, MemReadData;

    always #5 Clock = ~Clock;

    load_store_unit dut (
        .Clock(Clock), .ResetN(ResetN),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqByte(ReqByte),
        .ReqSigned(ReqSigned), .ReqAddress(ReqAddress), .ReqWriteData(ReqWriteData),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData), .RespFault(RespFault),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemReadData(MemReadData)
    );

    int tests = 0, fails = 0;

    // Attached memory (written by the DUT or by preload) and the model's view of it
    logic [7:0] mem     [0:127];
    logic [7:0] ref_mem [0:127];
    logic       pl_en = 1'b0;
    logic [6:0] pl_addr = '0;
    logic [7:0] pl_val = '0;

    always_comb begin
        MemReadData = '0;
        if (MemAddress <= 24'd125)
            MemReadData = {mem[MemAddress[6:0]], mem[MemAddress[6:0] + 7'd1], mem[MemAddress[6:0] + 7'd2]};
    end

    always @(posedge Clock) begin
        if (pl_en) mem[pl_addr] <= pl_val;
        else if (MemWrite && MemAddress <= 24'd125) begin
            mem[MemAddress[6:0]]        <= MemWriteData[23:16];
            mem[MemAddress[6:0] + 7'd1] <= MemWriteData[15:8];
            mem[MemAddress[6:0] + 7'd2] <= MemWriteData[7:0];
        end
    end

    typedef struct {logic fault; logic [23:0] data;} resp_t;
    resp_t       exp_q[$];
    logic        cur_vld = 1'b0, cur_fault = 1'b0, cur_byte = 1'b0;
    logic [23:0] cur_addr = '0, cur_wdata = '0, last_wdata = '0;
    int          rd_cnt = 0, wr_cnt = 0;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle check of memory-side and response outputs against the current expected transaction
    always @(negedge Clock) begin
        if (ResetN) begin
            chk("strobe_excl", 24'(MemRead & MemWrite), 24'd0);
            if (MemRead || MemWrite) begin
                chk("strobe_unexpected", 24'(cur_fault | !cur_vld), 24'd0);
                chk("mem_addr", MemAddress, cur_addr);
                if (MemRead) begin
                    rd_cnt++;
                    chk("rd_wdata_zero", MemWriteData, 24'd0);
                end
                if (MemWrite) begin
                    wr_cnt++;
                    last_wdata = MemWriteData;
                    chk("mem_wdata", MemWriteData, cur_wdata);
                    if (cur_byte) chk("rmw_order", 24'(rd_cnt), 24'd1);
                end
            end else begin
                chk("idle_addr", MemAddress, 24'd0);
                chk("idle_wdata", MemWriteData, 24'd0);
            end
            if (RespValid) begin
                if (exp_q.size() == 0) chk("resp_unexpected", 24'd1, 24'd0);
                else begin
                    chk("resp_data", RespData, exp_q[0].data);
                    chk("resp_fault", 24'(RespFault), 24'(exp_q[0].fault));
                end
            end
        end
    end

    task automatic preload(input int a, input logic [7:0] v);
        pl_en = 1'b1; pl_addr = 7'(a); pl_val = v; ref_mem[a] = v;
        @(posedge Clock);
        #1 pl_en = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic b, input logic s, input logic [23:0] a,
                          input logic [23:0] d, input int hold,
                          output logic [23:0] rdata, output logic rfault);
        int n, ai, exp_lat, exp_rd, exp_wr;
        resp_t e;
        n = 0;
        while (!ReqReady && n < 20) begin @(negedge Clock); n++; end
        chk("req_ready", 24'(ReqReady), 24'd1);
        ReqValid = 1'b1; ReqWrite = w; ReqByte = b; ReqSigned = s; ReqAddress = a; ReqWriteData = d;
        @(posedge Clock);
        e.fault = (a > 24'd125);
        e.data  = '0;
        ai = int'(a[6:0]);
        cur_vld = 1'b1; cur_fault = e.fault; cur_byte = b; cur_addr = a; cur_wdata = '0;
        rd_cnt = 0; wr_cnt = 0;
        if (e.fault) begin
            exp_lat = 0; exp_rd = 0; exp_wr = 0;
        end else if (!w) begin
            exp_lat = 1; exp_rd = 1; exp_wr = 0;
            if (!b)     e.data = {ref_mem[ai], ref_mem[ai+1], ref_mem[ai+2]};
            else if (s) e.data = {{16{ref_mem[ai][7]}}, ref_mem[ai]};
            else        e.data = {16'h0000, ref_mem[ai]};
        end else if (!b) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 1;
            cur_wdata = d;
            ref_mem[ai] = d[23:16]; ref_mem[ai+1] = d[15:8]; ref_mem[ai+2] = d[7:0];
        end else begin
            exp_lat = 2; exp_rd = 1; exp_wr = 1;
            cur_wdata = {d[7:0], ref_mem[ai+1], ref_mem[ai+2]};
            ref_mem[ai] = d[7:0];
        end
        exp_q.push_back(e);
        #1 ReqValid = 1'b0; ReqWrite = 1'b0; ReqByte = 1'b0; ReqSigned = 1'b0;
        n = 0;
        @(negedge Clock);
        while (!RespValid && n < 10) begin @(negedge Clock); n++; end
        chk("latency", 24'(n), 24'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            chk("hold_req_ready", 24'(ReqReady), 24'd0);
            chk("hold_resp_valid", 24'(RespValid), 24'd1);
            ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddress = 24'h000050; ReqWriteData = 24'h5A5A5A;
            @(negedge Clock);
            ReqValid = 1'b0; ReqWrite = 1'b0;
        end
        rdata = RespData; rfault = RespFault;
        RespReady = 1'b1;
        @(posedge Clock);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        #1 RespReady = 1'b0;
        chk("rd_count", 24'(rd_cnt), 24'(exp_rd));
        chk("wr_count", 24'(wr_cnt), 24'(exp_wr));
        cur_vld = 1'b0; cur_fault = 1'b0; cur_byte = 1'b0;
    endtask

    initial begin
        logic [23:0] d;
        logic        f;
        // Hold reset while the memory is filled
        for (int i = 0; i < 128; i++) preload(i, 8'((i * 37 + 5) & 8'hFF));
        preload(32'h20, 8'h11); preload(32'h21, 8'h22); preload(32'h22, 8'h33);
        preload(32'h30, 8'h80);
        #2;
        chk("rst_req_ready", 24'(ReqReady), 24'd0);
        chk("rst_outputs", {RespData[21:0], RespValid, RespFault} | MemAddress | MemWriteData
                           | 24'({MemWrite, MemRead}), 24'd0);
        @(negedge Clock) ResetN = 1'b1;
        #1 chk("post_rst_ready", 24'(ReqReady), 24'd1);
        chk("post_rst_resp_valid", 24'(RespValid), 24'd0);

        // Word store then load
        do_req(1'b1, 1'b0, 1'b0, 24'h000010, 24'hA1B2C3, 0, d, f);
        chk("word_store_resp", d, 24'd0);
        do_req(1'b0, 1'b0, 1'b0, 24'h000010, 24'h0, 0, d, f);
        chk("word_load_lit", d, 24'hA1B2C3);
        chk("word_load_fault", 24'(f), 24'd0);
        chk("word_mem_lit", {mem[16], mem[17], mem[18]}, 24'hA1B2C3);

        // Byte store read-modify-write
        do_req(1'b1, 1'b1, 1'b0, 24'h000020, 24'h0000FE, 0, d, f);
        chk("rmw_wdata_lit", last_wdata, 24'hFE2233);
        chk("rmw_mem_lit", {mem[32], mem[33], mem[34]}, 24'hFE2233);

        // Byte load extension
        do_req(1'b0, 1'b1, 1'b1, 24'h000030, 24'h0, 0, d, f);
        chk("byte_sext_lit", d, 24'hFFFF80);
        do_req(1'b0, 1'b1, 1'b0, 24'h000030, 24'h0, 0, d, f);
        chk("byte_zext_lit", d, 24'h000080);

        // Range boundary
        do_req(1'b0, 1'b0, 1'b0, 24'h00007E, 24'h0, 0, d, f);
        chk("fault_7e_lit", 24'(f), 24'd1);
        chk("fault_7e_data", d, 24'd0);
        do_req(1'b1, 1'b0, 1'b0, 24'h00007E, 24'h123456, 0, d, f);
        chk("fault_7e_store", 24'(f), 24'd1);
        do_req(1'b1, 1'b0, 1'b0, 24'h00007D, 24'hC0FFEE, 0, d, f);
        chk("edge_7d_store", 24'(f), 24'd0);
        do_req(1'b0, 1'b0, 1'b0, 24'h00007D, 24'h0, 0, d, f);
        chk("edge_7d_lit", d, 24'hC0FFEE);
        do_req(1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'h0, 0, d, f);
        chk("fault_ffffff_lit", 24'(f), 24'd1);

        // Response backpressure with ignored request pulses
        do_req(1'b0, 1'b0, 1'b0, 24'h000010, 24'h0, 5, d, f);
        chk("backpressure_lit", d, 24'hA1B2C3);

        // Reset in the middle of a STORE cycle
        @(negedge Clock);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqByte = 1'b0; ReqAddress = 24'h000040; ReqWriteData = 24'h123456;
        @(posedge Clock);
        #1 ReqValid = 1'b0; ReqWrite = 1'b0;
        #2 chk("store_strobe_before_rst", 24'(MemWrite), 24'd1);
        ResetN = 1'b0;
        #1;
        chk("midrst_req_ready", 24'(ReqReady), 24'd0);
        chk("midrst_outputs", RespData | MemAddress | MemWriteData
                              | 24'({RespValid, RespFault, MemWrite, MemRead}), 24'd0);
        @(posedge Clock);
        @(negedge Clock) ResetN = 1'b1;
        #1 chk("midrst_ready_after", 24'(ReqReady), 24'd1);
        chk("midrst_mem_unchanged", {mem[64], mem[65], mem[66]}, {ref_mem[64], ref_mem[65], ref_mem[66]});
        do_req(1'b0, 1'b0, 1'b0, 24'h000040, 24'h0, 0, d, f);

        // Whole memory against the model
        for (int i = 0; i < 128; i++) chk("final_mem", 24'(mem[i]), 24'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
